// File: rtl/nios_core_timer_mc.sv
// nios_core_timer_mc: multi-channel Avalon-MM interval timer with prescalers, snapshots and per-channel IRQs
module nios_core_timer_mc #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1+$clog2(NUM_CH):0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic                       irq,
  output logic [NUM_CH-1:0]          irq_vec,
  output logic [NUM_CH-1:0]          timeout_pulse
);
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DP = CNT_W'(DEFAULT_PERIOD);
  logic [NUM_CH-1:0][CNT_W-1:0] r_cnt, r_per, r_snap;
  logic [NUM_CH-1:0][7:0]       r_presc, r_pre;
  logic [NUM_CH-1:0]            r_run, r_to, r_ito, r_cont, r_pulse;
  logic [31:0]                  r_readdata;
  logic [CHW-1:0]               w_ch;
  logic [1:0]                   w_reg;
  logic                         w_ch_ok, w_wr;
  logic [NUM_CH-1:0]            w_sel, w_ctl, w_start, w_tick, w_to;
  logic [31:0]                  w_rd;
  assign w_ch    = CHW'(address >> 2);
  assign w_reg   = address[1:0];
  assign w_ch_ok = int'(w_ch) < NUM_CH;
  assign w_wr    = chipselect & ~write_n & w_ch_ok;
  always_comb begin
    w_sel   = '0;
    w_ctl   = '0;
    w_start = '0;
    w_tick  = '0;
    w_to    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c]   = w_wr && w_ch == CHW'(c);
      w_ctl[c]   = w_sel[c] && w_reg == 2'd1;
      w_start[c] = w_ctl[c] && writedata[2];
      w_tick[c]  = r_run[c] && r_pre[c] == r_presc[c];
      w_to[c]    = w_tick[c] && r_cnt[c] == '0;
    end
  end
  always_comb begin
    w_rd = !w_ch_ok      ? 32'd0 :
           w_reg == 2'd0 ? {30'd0, r_run[w_ch], r_to[w_ch]} :
           w_reg == 2'd1 ? {16'd0, r_presc[w_ch], 6'd0, r_cont[w_ch], r_ito[w_ch]} :
           w_reg == 2'd2 ? 32'(r_per[w_ch]) : 32'(r_snap[w_ch]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= {NUM_CH{DP}};
      r_per      <= {NUM_CH{DP}};
      r_snap     <= '0;
      r_presc    <= '0;
      r_pre      <= '0;
      r_run      <= '0;
      r_to       <= '0;
      r_ito      <= '0;
      r_cont     <= '0;
      r_pulse    <= '0;
      r_readdata <= '0;
    end else begin
      r_pulse    <= w_to;
      r_readdata <= w_rd;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_sel[c] && w_reg == 2'd2) begin
          r_per[c] <= writedata[CNT_W-1:0];
          r_cnt[c] <= writedata[CNT_W-1:0];
          r_pre[c] <= '0;
          r_run[c] <= 1'b0;
        end else begin
          if (w_tick[c]) r_cnt[c] <= w_to[c] ? r_per[c] : r_cnt[c] - 1'b1;
          r_pre[c] <= (!r_run[c] || w_tick[c] || w_start[c]) ? '0 : r_pre[c] + 8'd1;
          // an explicit START/STOP overrides the one-shot auto-stop; START beats STOP
          if (w_ctl[c] && (writedata[2] || writedata[3])) r_run[c] <= writedata[2];
          else if (w_to[c] && !r_cont[c]) r_run[c] <= 1'b0;
        end
        if (w_ctl[c]) begin
          r_ito[c]   <= writedata[0];
          r_cont[c]  <= writedata[1];
          r_presc[c] <= writedata[15:8];
        end
        r_to[c] <= w_to[c] || (r_to[c] && !(w_sel[c] && w_reg == 2'd0));
        if (w_sel[c] && w_reg == 2'd3) r_snap[c] <= r_cnt[c];
      end
    end
  end
  assign readdata      = r_readdata;
  assign irq_vec       = r_to & r_ito;
  assign irq           = |irq_vec;
  assign timeout_pulse = r_pulse;
endmodule

// File: doc/nios_core_timer_mc.md
# nios_core_timer_mc

Multi-channel interval timer: the parametrised successor to the single-channel Nios interval timer in the `nios_core` system. It provides NUM_CH independent down-counters of parametrised width behind one Avalon-MM slave, each with a programmable prescaler, one-shot/continuous mode, snapshot capture and its own interrupt. It sits on the Nios data master, drives a combined IRQ line to the CPU, and gives other fabric blocks per-channel timeout pulses for hardware triggering.

## Interface
- NUM_CH, 4, number of channels (1..8)
- CNT_W, 32, counter/period width (8..32)
- DEFAULT_PERIOD, 49999, reset value of every PERIOD register and counter
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2+clog2(NUM_CH)  word address; [1:0] = register, upper bits = channel
- chipselect  in  1  slave select
- write_n  in  1  active-low write
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  OR of all channel interrupts
- irq_vec  out  NUM_CH  per-channel interrupt (TO & ITO)
- timeout_pulse  out  NUM_CH  one-cycle pulse per channel timeout

## Operation
- Write strobe = chipselect & ~write_n. Per-channel register map (reg = address[1:0]):
- 0 STATUS: read {30'b0, RUN, TO}. Any write clears TO.
- 1 CONTROL: bit0 ITO (irq enable), bit1 CONT, bit2 START (strobe), bit3 STOP (strobe), bits[15:8] PRESC. Read returns {16'b0, PRESC, 4'b0, 2'b0, CONT, ITO}; START and STOP always read 0.
- 2 PERIOD: write loads period[CNT_W-1:0], loads counter with the written value, clears RUN and the prescaler. Read is zero-extended.
- 3 SNAP: any write captures the current counter. Read returns the snapshot, zero-extended.
- Prescaler: pre_cnt counts 0..PRESC. tick = RUN & (pre_cnt == PRESC). pre_cnt is held at 0 while RUN=0, and is zeroed on START and on a PERIOD write.
- On tick with counter != 0: counter decrements by 1.
- On tick with counter == 0:
  - counter reloads PERIOD;
  - TO is set;
  - timeout_pulse asserts for 1 cycle;
  - RUN clears if CONT=0.
- Timeout interval = (PERIOD+1)*(PRESC+1) clk cycles.
- START sets RUN; STOP clears RUN. START and STOP in the same write: START wins.
- Clearing STATUS in the same cycle as a timeout: the timeout wins and TO stays 1.
- Counter value is held while RUN=0. START resumes from the held value.
- PERIOD=0: with PRESC=0, a timeout occurs every cycle while running.
- Writes to channels ≥ NUM_CH are ignored; reads from them return 0.
- Reset values:
  - counter = DEFAULT_PERIOD; PERIOD = DEFAULT_PERIOD;
  - RUN, TO, ITO, CONT, PRESC, snapshot = 0;
  - readdata = 0; irq = 0; irq_vec = 0; timeout_pulse = 0.
  - Reset asserted mid-count aborts the count; the timer comes out of reset in the reset-value state with no pending TO.

## Timing
- All register writes take effect at the clock edge that samples the strobe. Values are visible from the next cycle.
- Read latency 1: readdata is updated every cycle from the address (chipselect not required) and is valid the cycle after address is presented. No wait states.
- START at edge N → RUN=1 after N. The first tick occurs at edge N+1+PRESC, which is the first decrement.
- The timeout edge sets TO, irq_vec, irq and timeout_pulse together (all registered). irq falls 1 cycle after the clearing STATUS write edge.
- SNAP captures the counter value present before the capturing edge.

## Test plan
- Reset then read all registers of channel 0 → PERIOD=49999, counter snapshot 0, STATUS=0, CONTROL=0; irq=0.
- Ch1: PERIOD=4, PRESC=0, CONTROL=ITO|CONT|START → timeout_pulse[1] every 5 cycles, TO=1, irq=1; STATUS write clears irq the next cycle; counting continues uninterrupted.
- Ch2: PERIOD=3, PRESC=2, one-shot START → one timeout at 12 cycles after START; RUN=0 afterwards; counter=3 held; no further pulses.
- Ch0: running, write SNAP twice 7 cycles apart with PRESC=0 → snapshots differ by 7 (mod PERIOD+1). PERIOD write mid-count → RUN=0, counter = new value.
- Simultaneous events:
  - CONTROL write START|STOP → RUN=1.
  - STATUS clear on the timeout edge → TO remains 1.
  - Two channels timing out on the same edge → irq_vec shows both bits; irq stays 1 until both are cleared.
- Assert reset mid-count on all channels → all outputs return to reset values on the next edge; the channels do not run until START.
